// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 round sequencer: round count, index width,
// FSM encoding and the delay-line entry format.
package aes_pkg;

  localparam int AES_NR = 10;
  localparam int IDX_W  = 4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_KS_RST  = 3'd1;
  localparam logic [2:0] ST_KS_WAIT = 3'd2;
  localparam logic [2:0] ST_ISSUE   = 3'd3;
  localparam logic [2:0] ST_DRAIN   = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } rnd_ent_t;

  function automatic logic is_busy_state(input logic [2:0] s);
    return (s == ST_KS_RST) || (s == ST_KS_WAIT) || (s == ST_ISSUE) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Command, key-schedule and round-datapath signals of the AES round sequencer.
interface aes_round_ctrl_if;
  import aes_pkg::*;

  logic             Start;
  logic             Abort;
  logic             Hold;
  logic             Busy;
  logic             Done;
  logic             Err;
  logic             KsRst;
  logic             KsEn;
  logic             KsRy;
  logic [IDX_W-1:0] KsSel;
  logic             RndEn;
  logic [IDX_W-1:0] RndIdx;
  logic             LoadState;
  logic             FinalRnd;

  modport master (
    output Start, Abort, Hold, KsRy,
    input  Busy, Done, Err, KsRst, KsEn, KsSel, RndEn, RndIdx, LoadState, FinalRnd
  );

  modport slave (
    input  Start, Abort, Hold, KsRy,
    output Busy, Done, Err, KsRst, KsEn, KsSel, RndEn, RndIdx, LoadState, FinalRnd
  );

endinterface

// File: rtl/aes_ctrl_dly.sv
// DEPTH-stage shift register carrying {valid, idx}, advanced by a shared enable
// so a stalled datapath freezes every stage together.
module aes_ctrl_dly
  import aes_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic     Clk,
  input  logic     Rst,
  input  logic     clr,
  input  logic     en,
  input  rnd_ent_t din,
  output rnd_ent_t dout
);

  rnd_ent_t stage_reg [DEPTH];

  always_ff @(posedge Clk) begin
    if (Rst || clr) begin
      for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
    end else if (en) begin
      stage_reg[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
    end
  end

  assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: kicks the key schedule, then issues round-key selects
// and emits round strobes aligned with the key-schedule latency.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR         = AES_NR,
  parameter int KS_LAT     = 1,
  parameter int RY_TIMEOUT = 15
) (
  input logic             Clk,
  input logic             Rst,
  aes_round_ctrl_if.slave bus
);

  localparam logic [IDX_W-1:0] NR_IDX   = IDX_W'(NR);
  localparam logic [IDX_W-1:0] TMO_LAST = IDX_W'(RY_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

  logic [2:0]       state_reg, state_next;
  logic [IDX_W-1:0] r_reg, r_next;
  logic [IDX_W-1:0] tmo_reg, tmo_next;
  logic             err_reg, err_next;
  logic             issue, shift_en, abort_act, dly_clr, rnd_ok;
  rnd_ent_t         dly_in, dly_out;

  assign abort_act = bus.Abort && (state_reg != ST_IDLE);

  always_comb begin
    state_next = state_reg;
    r_next     = r_reg;
    tmo_next   = tmo_reg;
    err_next   = err_reg;
    issue      = 1'b0;
    shift_en   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.Start && !bus.Abort) state_next = ST_KS_RST;
      end
      ST_KS_RST: begin
        tmo_next   = '0;
        err_next   = 1'b0;
        r_next     = '0;
        state_next = ST_KS_WAIT;
      end
      ST_KS_WAIT: begin
        // The ready cycle already presents KsSel=0, so round 0 is issued here.
        if (bus.KsRy) begin
          issue      = 1'b1;
          state_next = ST_ISSUE;
        end else if (tmo_reg == TMO_LAST) begin
          err_next   = 1'b1;
          state_next = ST_DONE;
        end else begin
          tmo_next = tmo_reg + ONE;
        end
      end
      ST_ISSUE: begin
        if (!bus.Hold) begin
          issue = 1'b1;
          if (r_reg == NR_IDX) state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!bus.Hold) begin
          shift_en = 1'b1;
          if (dly_out.valid && (dly_out.idx == NR_IDX)) begin
            r_next     = '0;
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (issue) begin
      shift_en = 1'b1;
      if (r_reg != NR_IDX) r_next = r_reg + ONE;
    end

    if (abort_act) begin
      state_next = ST_IDLE;
      r_next     = '0;
      tmo_next   = '0;
      err_next   = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg <= ST_IDLE;
      r_reg     <= '0;
      tmo_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      r_reg     <= r_next;
      tmo_reg   <= tmo_next;
      err_reg   <= err_next;
    end
  end

  // Only issued rounds carry an index so the line drains to all-zero.
  assign dly_in  = '{valid: issue, idx: (issue ? r_reg : '0)};
  assign dly_clr = abort_act || (state_reg == ST_KS_RST);

  aes_ctrl_dly #(.DEPTH(KS_LAT)) u_dly (
    .Clk  (Clk),
    .Rst  (Rst),
    .clr  (dly_clr),
    .en   (shift_en),
    .din  (dly_in),
    .dout (dly_out)
  );

  assign rnd_ok = ((state_reg == ST_ISSUE) || (state_reg == ST_DRAIN)) && !bus.Hold && dly_out.valid;

  assign bus.Busy      = is_busy_state(state_reg);
  assign bus.Done      = (state_reg == ST_DONE);
  assign bus.Err       = (state_reg == ST_DONE) && err_reg;
  assign bus.KsRst     = (state_reg == ST_KS_RST);
  assign bus.KsEn      = (state_reg == ST_KS_WAIT);
  assign bus.KsSel     = r_reg;
  assign bus.RndEn     = rnd_ok;
  assign bus.RndIdx    = dly_out.idx;
  assign bus.LoadState = rnd_ok && (dly_out.idx == '0);
  assign bus.FinalRnd  = rnd_ok && (dly_out.idx == NR_IDX);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl with KS_LAT=1 and KS_LAT=3 instances.
module tb_aes_round_ctrl;
  import aes_pkg::*;

  localparam int NR = AES_NR;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  logic start_d, abort_d, hold_d, sel;
  int   ry_dly;
  int   en_cnt1, en_cnt3;
  int   n_chk, n_fail, cur_c;
  int   shift_cyc [0:15];

  aes_round_ctrl_if if1 ();
  aes_round_ctrl_if if3 ();

  aes_round_ctrl #(.NR(NR), .KS_LAT(1), .RY_TIMEOUT(15)) dut1 (.Clk(Clk), .Rst(Rst), .bus(if1.slave));
  aes_round_ctrl #(.NR(NR), .KS_LAT(3), .RY_TIMEOUT(15)) dut3 (.Clk(Clk), .Rst(Rst), .bus(if3.slave));

  assign if1.Start = start_d & ~sel;
  assign if3.Start = start_d & sel;
  assign if1.Abort = abort_d & ~sel;
  assign if3.Abort = abort_d & sel;
  assign if1.Hold  = hold_d & ~sel;
  assign if3.Hold  = hold_d & sel;

  // Key-schedule model: ready after ry_dly enabled cycles, cleared by KsRst.
  always @(posedge Clk) begin
    if (Rst || if1.KsRst) en_cnt1 <= 0; else if (if1.KsEn) en_cnt1 <= en_cnt1 + 1;
    if (Rst || if3.KsRst) en_cnt3 <= 0; else if (if3.KsEn) en_cnt3 <= en_cnt3 + 1;
  end
  assign if1.KsRy = (en_cnt1 >= ry_dly);
  assign if3.KsRy = (en_cnt3 >= ry_dly);

  logic       o_busy, o_done, o_err, o_ksrst, o_ksen, o_rnden, o_load, o_final;
  logic [3:0] o_kssel, o_rndidx;
  assign o_busy   = sel ? if3.Busy      : if1.Busy;
  assign o_done   = sel ? if3.Done      : if1.Done;
  assign o_err    = sel ? if3.Err       : if1.Err;
  assign o_ksrst  = sel ? if3.KsRst     : if1.KsRst;
  assign o_ksen   = sel ? if3.KsEn      : if1.KsEn;
  assign o_kssel  = sel ? if3.KsSel     : if1.KsSel;
  assign o_rnden  = sel ? if3.RndEn     : if1.RndEn;
  assign o_rndidx = sel ? if3.RndIdx    : if1.RndIdx;
  assign o_load   = sel ? if3.LoadState : if1.LoadState;
  assign o_final  = sel ? if3.FinalRnd  : if1.FinalRnd;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cur_c, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".Busy"},      int'(o_busy),   0);
    chk({tag, ".Done"},      int'(o_done),   0);
    chk({tag, ".Err"},       int'(o_err),    0);
    chk({tag, ".KsRst"},     int'(o_ksrst),  0);
    chk({tag, ".KsEn"},      int'(o_ksen),   0);
    chk({tag, ".KsSel"},     int'(o_kssel),  0);
    chk({tag, ".RndEn"},     int'(o_rnden),  0);
    chk({tag, ".RndIdx"},    int'(o_rndidx), 0);
    chk({tag, ".LoadState"}, int'(o_load),   0);
    chk({tag, ".FinalRnd"},  int'(o_final),  0);
  endtask

  function automatic logic hold_at(input logic [63:0] h, input int c);
    logic [5:0] bi;
    bi = c[5:0];
    return (c >= 0 && c < 64) ? h[bi] : 1'b0;
  endfunction

  // Reference: every non-Hold cycle from the first ready cycle advances the
  // pipeline; round i leaves the line on advance number i+lat.
  task automatic build_model(input int lat, input int ry, input logic [63:0] hold,
                             output int done, output bit tmo, output int f);
    int k, c;
    if (ry > 14) begin
      tmo = 1'b1; done = 17; f = -1;
    end else begin
      tmo = 1'b0; f = 2 + ry; k = 0; c = f;
      while (k <= NR + lat) begin
        if (c == f || !hold_at(hold, c)) begin
          shift_cyc[k] = c;
          k++;
        end
        c++;
      end
      done = shift_cyc[NR + lat] + 1;
    end
  endtask

  task automatic run_scn(input string tag, input int lat, input int ry, input logic [63:0] hold,
                         input int kill_at, input bit kill_rst,
                         output int obs_done, output int obs_err, output int obs_first, output int obs_last);
    int done, f, last_c, n, e_sel, e_idx, e_rnden;
    bit tmo;
    build_model(lat, ry, hold, done, tmo, f);
    ry_dly = ry;
    sel    = (lat == 3);
    last_c = (kill_at >= 0) ? kill_at + 1 : done;
    obs_done = -1; obs_err = -1; obs_first = -1; obs_last = -1;
    for (int c = 0; c <= last_c; c++) begin
      cur_c   = c;
      start_d = (c == 0) || (kill_rst && c == kill_at) ||
                (c > 0 && c < last_c && $urandom_range(1, 0) == 1);
      hold_d  = hold_at(hold, c);
      abort_d = (c == kill_at) && !kill_rst;
      Rst     = (c == kill_at) && kill_rst;
      @(negedge Clk);
      if (kill_at >= 0 && c == kill_at + 1) begin
        chk_idle({tag, ".kill"});
      end else begin
        e_rnden = 0; e_idx = 0;
        if (!tmo)
          for (int i = 0; i <= NR; i++)
            if (shift_cyc[i + lat] == c) begin e_rnden = 1; e_idx = i; end
        chk({tag, ".Busy"},  int'(o_busy),  int'(c >= 1 && c < done));
        chk({tag, ".Done"},  int'(o_done),  int'(c == done));
        chk({tag, ".Err"},   int'(o_err),   int'(c == done && tmo));
        chk({tag, ".KsRst"}, int'(o_ksrst), int'(c == 1));
        chk({tag, ".KsEn"},  int'(o_ksen),  int'(c >= 2 && c <= (tmo ? 16 : f)));
        chk({tag, ".RndEn"}, int'(o_rnden), e_rnden);
        chk({tag, ".LoadState"}, int'(o_load),  int'(e_rnden == 1 && e_idx == 0));
        chk({tag, ".FinalRnd"},  int'(o_final), int'(e_rnden == 1 && e_idx == NR));
        if (e_rnden == 1) chk({tag, ".RndIdx"}, int'(o_rndidx), e_idx);
        if (c < done) begin
          e_sel = 0;
          if (!tmo && c >= f) begin
            n = 0;
            for (int i = 0; i <= NR; i++) if (shift_cyc[i] < c) n++;
            e_sel = (n > NR) ? NR : n;
          end
          chk({tag, ".KsSel"}, int'(o_kssel), e_sel);
        end
      end
      if (o_done && obs_done < 0) begin obs_done = c; obs_err = int'(o_err); end
      if (o_rnden) begin
        if (obs_first < 0) obs_first = c;
        obs_last = c;
      end
      @(posedge Clk);
      #1;
    end
    start_d = 1'b0; abort_d = 1'b0; hold_d = 1'b0; Rst = 1'b0;
  endtask

  typedef struct {
    int          lat;
    int          ry;
    logic [63:0] hold;
    int          exp_done;
    int          exp_err;
    int          exp_first;
    int          exp_last;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int d, e, fi, la, lat, ry;
    logic [63:0] hm;
    vecs[0] = '{lat: 1, ry: 1,   hold: 64'd0,                          exp_done: 15, exp_err: 0, exp_first: 4,  exp_last: 14};
    vecs[1] = '{lat: 1, ry: 1,   hold: (64'd1 << 7) | (64'd1 << 8),    exp_done: 17, exp_err: 0, exp_first: 4,  exp_last: 16};
    vecs[2] = '{lat: 1, ry: 100, hold: 64'd0,                          exp_done: 17, exp_err: 1, exp_first: -1, exp_last: -1};
    vecs[3] = '{lat: 3, ry: 1,   hold: 64'd0,                          exp_done: 17, exp_err: 0, exp_first: 6,  exp_last: 16};
    vecs[4] = '{lat: 3, ry: 3,   hold: (64'd1 << 5) | (64'd1 << 10),   exp_done: 20, exp_err: 0, exp_first: 8,  exp_last: 19};

    n_chk = 0; n_fail = 0; cur_c = -1;
    Rst = 1'b1; start_d = 1'b0; abort_d = 1'b0; hold_d = 1'b0; sel = 1'b0; ry_dly = 1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    sel = 1'b0; #1; chk_idle("reset1");
    sel = 1'b1; #1; chk_idle("reset3");
    sel = 1'b0;
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(posedge Clk); #1;

    for (int v = 0; v < 5; v++) begin
      run_scn($sformatf("vec%0d", v), vecs[v].lat, vecs[v].ry, vecs[v].hold, -1, 1'b0, d, e, fi, la);
      chk($sformatf("vec%0d.done_cycle", v), d,  vecs[v].exp_done);
      chk($sformatf("vec%0d.err", v),        e,  vecs[v].exp_err);
      chk($sformatf("vec%0d.first_rnd", v),  fi, vecs[v].exp_first);
      chk($sformatf("vec%0d.last_rnd", v),   la, vecs[v].exp_last);
    end

    run_scn("abort9", 1, 1, 64'd0, 9, 1'b0, d, e, fi, la);
    chk("abort9.no_done", d, -1);
    run_scn("after_abort", 1, 1, 64'd0, -1, 1'b0, d, e, fi, la);
    chk("after_abort.done_cycle", d, 15);

    run_scn("rst6", 1, 1, 64'd0, 6, 1'b1, d, e, fi, la);
    chk("rst6.no_done", d, -1);
    run_scn("after_rst", 3, 1, 64'd0, -1, 1'b0, d, e, fi, la);
    chk("after_rst.done_cycle", d, 17);

    for (int t = 0; t < 25; t++) begin
      lat = ($urandom_range(1, 0) == 1) ? 3 : 1;
      ry  = ($urandom_range(9, 0) == 0) ? 20 : int'($urandom_range(6, 1));
      hm  = {$urandom, $urandom} & {$urandom, $urandom};
      run_scn($sformatf("rand%0d", t), lat, ry, hm, -1, 1'b0, d, e, fi, la);
    end

    repeat (2) @(posedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
